// File: rtl/sn76489_write_arbiter.sv
// Two-requester write arbiter for the sn76489 CPU port: one-byte holding register per
// requester, round-robin grant, timed nWE/nCE strobe, and an atomic tone-frequency latch/data pair.
module sn76489_write_arbiter #(
    parameter int WE_CYCLES    = 2,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       a_valid,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [7:0] b_data,
    output logic       b_ready,
    output logic [7:0] psg_d,
    output logic       psg_nWE,
    output logic       psg_nCE,
    input  logic       psg_ready,
    output logic       busy,
    output logic       lock_active
);

    localparam int SW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam int LW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t          state_q;
    logic            full_a_q, full_b_q;
    logic [7:0]      buf_a_q, buf_b_q;
    logic            last_grant_q;      // 0 = A, 1 = B
    logic [SW-1:0]   strobe_cnt_q;
    logic [7:0]      psg_d_q;
    logic            psg_nwe_q, psg_nce_q;
    logic            busy_q;
    logic            lock_active_q;
    logic            lock_owner_q;      // 0 = A, 1 = B
    logic [LW-1:0]   lock_cnt_q;

    logic            lock_eff_d;
    logic            elig_a_d, elig_b_d;
    logic            grant_d, grant_sel_d;
    logic [7:0]      grant_byte_d;

    // Tone frequency latch: latch bit set, not a volume register, not the noise channel.
    function automatic logic is_freq_latch(input logic [7:0] b);
        return b[7] & ~b[4] & (b[6:5] != 2'b11);
    endfunction

    assign a_ready     = ~full_a_q & ~reset;
    assign b_ready     = ~full_b_q & ~reset;
    assign psg_d       = psg_d_q;
    assign psg_nWE     = psg_nwe_q;
    assign psg_nCE     = psg_nce_q;
    assign busy        = busy_q;
    assign lock_active = lock_active_q;

    // Grant selection; a lock on its final count no longer blocks the other requester.
    always_comb begin
        lock_eff_d  = lock_active_q & (lock_cnt_q != {LW{1'b0}});
        elig_a_d    = full_a_q & (~lock_eff_d | (lock_owner_q == 1'b0));
        elig_b_d    = full_b_q & (~lock_eff_d | (lock_owner_q == 1'b1));
        grant_d     = 1'b0;
        grant_sel_d = 1'b0;
        if (state_q == ST_IDLE) begin
            if (elig_a_d && elig_b_d) begin
                grant_d     = 1'b1;
                grant_sel_d = ~last_grant_q;
            end else if (elig_a_d) begin
                grant_d     = 1'b1;
                grant_sel_d = 1'b0;
            end else if (elig_b_d) begin
                grant_d     = 1'b1;
                grant_sel_d = 1'b1;
            end else begin
                grant_d     = 1'b0;
                grant_sel_d = 1'b0;
            end
        end else begin
            grant_d     = 1'b0;
            grant_sel_d = 1'b0;
        end
        grant_byte_d = grant_sel_d ? buf_b_q : buf_a_q;
    end

    // Holding registers, write FSM with registered strobes, and the frequency-pair lock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            full_a_q      <= 1'b0;
            full_b_q      <= 1'b0;
            buf_a_q       <= 8'h00;
            buf_b_q       <= 8'h00;
            last_grant_q  <= 1'b1;
            strobe_cnt_q  <= {SW{1'b0}};
            psg_d_q       <= 8'h00;
            psg_nwe_q     <= 1'b1;
            psg_nce_q     <= 1'b1;
            busy_q        <= 1'b0;
            lock_active_q <= 1'b0;
            lock_owner_q  <= 1'b0;
            lock_cnt_q    <= {LW{1'b0}};
        end else begin
            if (a_valid && !full_a_q) begin
                full_a_q <= 1'b1;
                buf_a_q  <= a_data;
            end else if (grant_d && !grant_sel_d) begin
                full_a_q <= 1'b0;
            end
            if (b_valid && !full_b_q) begin
                full_b_q <= 1'b1;
                buf_b_q  <= b_data;
            end else if (grant_d && grant_sel_d) begin
                full_b_q <= 1'b0;
            end

            // Lags the state by one clock so it stays high through the final ready sample.
            busy_q <= (state_q != ST_IDLE) | full_a_q | full_b_q;

            case (state_q)
                ST_IDLE: begin
                    if (grant_d) begin
                        psg_d_q      <= grant_byte_d;
                        psg_nwe_q    <= 1'b0;
                        psg_nce_q    <= 1'b0;
                        last_grant_q <= grant_sel_d;
                        strobe_cnt_q <= SW'(WE_CYCLES - 1);
                        state_q      <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (strobe_cnt_q == {SW{1'b0}}) begin
                        psg_nwe_q <= 1'b1;
                        psg_nce_q <= 1'b1;
                        state_q   <= ST_WAIT;
                    end else begin
                        strobe_cnt_q <= strobe_cnt_q - SW'(1);
                    end
                end
                ST_WAIT: begin
                    if (psg_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    psg_nwe_q <= 1'b1;
                    psg_nce_q <= 1'b1;
                    state_q   <= ST_IDLE;
                end
            endcase

            if (grant_d && is_freq_latch(grant_byte_d)) begin
                lock_active_q <= 1'b1;
                lock_owner_q  <= grant_sel_d;
                lock_cnt_q    <= LW'(LOCK_TIMEOUT - 1);
            end else if (grant_d && lock_eff_d && (lock_owner_q == grant_sel_d)) begin
                lock_active_q <= 1'b0;
            end else if (lock_active_q) begin
                if (lock_cnt_q == {LW{1'b0}}) begin
                    lock_active_q <= 1'b0;
                end else begin
                    lock_cnt_q <= lock_cnt_q - LW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sn76489_write_arbiter.sv
// Scoreboard bench for sn76489_write_arbiter: expected bytes are queued as stimulus is
// driven and compared as each write strobe falls; strobe timing and lock timing are checked too.
module tb_sn76489_write_arbiter;

    localparam int WE_CYCLES    = 2;
    localparam int LOCK_TIMEOUT = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic [7:0] a_data = 8'h00, b_data = 8'h00;
    logic       a_ready, b_ready;
    logic [7:0] psg_d;
    logic       psg_nWE, psg_nCE;
    logic       psg_ready = 1'b1;
    logic       busy, lock_active;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         fall_cyc_q[$];
    int         fall_cnt = 0;
    int         last_fall_cyc = 0;
    int         lock_fall_cyc = -1;
    int         low_cnt = 0;
    logic       prev_nwe = 1'b1;
    logic       prev_lock = 1'b0;

    sn76489_write_arbiter #(.WE_CYCLES(WE_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .psg_d(psg_d), .psg_nWE(psg_nWE), .psg_nCE(psg_nCE), .psg_ready(psg_ready),
        .busy(busy), .lock_active(lock_active)
    );

    always #5 clock = ~clock;

    // Edge index: after rising edge k, cyc == k.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clock);
            if (prev_nwe && !psg_nWE) begin
                fall_cnt++;
                last_fall_cyc = cyc;
                fall_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) chk("sb_unexpected_strobe", 32'(exp_q.size()), 32'd1);
                else chk("sb_psg_d", {24'd0, psg_d}, {24'd0, exp_q.pop_front()});
                chk("nce_with_nwe", {31'd0, psg_nCE}, 32'd0);
            end
            if (!psg_nWE) low_cnt = prev_nwe ? 1 : low_cnt + 1;
            if (!prev_nwe && psg_nWE && !reset) chk("nwe_width", 32'(low_cnt), 32'(WE_CYCLES));
            if (prev_lock && !lock_active) lock_fall_cyc = cyc;
            prev_nwe  = psg_nWE;
            prev_lock = lock_active;
        end
    endtask

    task automatic send(input logic va, input logic vb, input logic [7:0] da,
                        input logic [7:0] db, output int acc);
        int k;
        k = 0;
        @(negedge clock);
        while (((va && !a_ready) || (vb && !b_ready)) && k < 100) begin
            @(negedge clock);
            k++;
        end
        chk("ready_wait", {31'd0, k < 100}, 32'd1);
        a_valid = va; b_valid = vb; a_data = da; b_data = db;
        @(posedge clock);
        #1;
        acc = cyc;
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic wait_falls(input int target);
        int k;
        k = 0;
        while (fall_cnt < target && k < 200) begin
            @(negedge clock);
            #1;
            k++;
        end
        chk("strobe_timeout", {31'd0, fall_cnt >= target}, 32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        int t, g, n, rr;
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog expired");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
        chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
        chk("rst_nwe", {31'd0, psg_nWE}, 32'd1);
        chk("rst_nce", {31'd0, psg_nCE}, 32'd1);
        chk("rst_psg_d", {24'd0, psg_d}, 32'h00);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_lock", {31'd0, lock_active}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rel_a_ready", {31'd0, a_ready}, 32'd1);

        // Single write: latency, width, busy tail
        n = fall_cnt;
        exp_q.push_back(8'h9F);
        send(1'b1, 1'b0, 8'h9F, 8'h00, t);
        wait_falls(n + 1);
        g = last_fall_cyc;
        chk("t1_grant_latency", 32'(g), 32'(t + 1));
        chk("t1_a_ready_after_grant", {31'd0, a_ready}, 32'd1);
        chk("t1_lock", {31'd0, lock_active}, 32'd0);
        repeat (3) @(negedge clock);
        chk("t1_busy_g3", {31'd0, busy}, 32'd1);
        @(negedge clock);
        chk("t1_busy_g4", {31'd0, busy}, 32'd0);
        chk("t1_psg_d_hold", {24'd0, psg_d}, 32'h9F);

        // Tie after reset: A first, grants 4 clocks apart
        pulse_reset();
        n = fall_cnt;
        fall_cyc_q.delete();
        exp_q.push_back(8'h90);
        exp_q.push_back(8'hB0);
        send(1'b1, 1'b1, 8'h90, 8'hB0, t);
        wait_falls(n + 2);
        chk("t2_first_grant", 32'(fall_cyc_q[0]), 32'(t + 1));
        chk("t2_spacing", 32'(fall_cyc_q[1] - fall_cyc_q[0]), 32'(WE_CYCLES + 2));
        repeat (8) @(negedge clock);

        // Lock held by A until its data byte
        n = fall_cnt;
        fall_cyc_q.delete();
        exp_q.push_back(8'h85);
        exp_q.push_back(8'h3F);
        exp_q.push_back(8'hDF);
        send(1'b1, 1'b0, 8'h85, 8'h00, t);
        send(1'b0, 1'b1, 8'h00, 8'hDF, rr);
        repeat (3) @(posedge clock);
        send(1'b1, 1'b0, 8'h3F, 8'h00, rr);
        chk("t3_3f_accept", 32'(rr), 32'(t + 5));
        chk("t3_lock_before_3f", {31'd0, lock_active}, 32'd1);
        wait_falls(n + 3);
        chk("t3_85_grant", 32'(fall_cyc_q[0]), 32'(t + 1));
        chk("t3_3f_grant", 32'(fall_cyc_q[1]), 32'(t + 6));
        chk("t3_lock_fall", 32'(lock_fall_cyc), 32'(t + 6));
        chk("t3_df_grant", 32'(fall_cyc_q[2]), 32'(t + 6 + WE_CYCLES + 2));
        repeat (8) @(negedge clock);

        // Lock timeout releases B
        n = fall_cnt;
        fall_cyc_q.delete();
        exp_q.push_back(8'h85);
        exp_q.push_back(8'hDF);
        send(1'b1, 1'b0, 8'h85, 8'h00, t);
        send(1'b0, 1'b1, 8'h00, 8'hDF, rr);
        wait_falls(n + 1);
        chk("t4_lock_set", {31'd0, lock_active}, 32'd1);
        wait_falls(n + 2);
        g = fall_cyc_q[0];
        chk("t4_df_grant", 32'(fall_cyc_q[1]), 32'(g + LOCK_TIMEOUT));
        chk("t4_lock_fall", 32'(lock_fall_cyc), 32'(g + LOCK_TIMEOUT));
        chk("t4_lock_after_df", {31'd0, lock_active}, 32'd0);
        repeat (8) @(negedge clock);

        // Stalled psg_ready
        n = fall_cnt;
        exp_q.push_back(8'h9F);
        exp_q.push_back(8'hE4);
        send(1'b1, 1'b0, 8'h9F, 8'h00, t);
        wait_falls(n + 1);
        psg_ready = 1'b0;
        send(1'b1, 1'b0, 8'hE4, 8'h00, t);
        repeat (20) @(negedge clock);
        chk("t5_no_strobe_stalled", 32'(fall_cnt), 32'(n + 1));
        chk("t5_busy_stalled", {31'd0, busy}, 32'd1);
        psg_ready = 1'b1;
        rr = cyc + 1;
        wait_falls(n + 2);
        chk("t5_resume", 32'(last_fall_cyc), 32'(rr + 1));
        repeat (8) @(negedge clock);

        // Reset in the middle of a strobe
        n = fall_cnt;
        exp_q.push_back(8'h42);
        send(1'b1, 1'b0, 8'h42, 8'h00, t);
        wait_falls(n + 1);
        chk("t6_nwe_low", {31'd0, psg_nWE}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_nwe_async", {31'd0, psg_nWE}, 32'd1);
        chk("t6_nce_async", {31'd0, psg_nCE}, 32'd1);
        chk("t6_a_ready_rst", {31'd0, a_ready}, 32'd0);
        chk("t6_b_ready_rst", {31'd0, b_ready}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("t6_a_ready_rel", {31'd0, a_ready}, 32'd1);
        chk("t6_b_ready_rel", {31'd0, b_ready}, 32'd1);
        chk("t6_lock_rel", {31'd0, lock_active}, 32'd0);
        n = fall_cnt;
        fall_cyc_q.delete();
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send(1'b1, 1'b1, 8'h11, 8'h22, t);
        wait_falls(n + 2);
        chk("t6_first_grant", 32'(fall_cyc_q[0]), 32'(t + 1));
        repeat (8) @(negedge clock);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
